// File: rtl/data_memory_responder.sv
// Wait-state data memory responder: IDLE/WAIT/RESP handshake stalling the processor LATENCY cycles.
// Define DATA_MEM_BOUNDS_CHECK_EN to flag and neutralise accesses at or beyond DEPTH.
module data_memory_responder #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 2
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [WORD_SIZE-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataOut,
  input  logic                 ReadData,
  input  logic                 WriteData,
  output logic [WORD_SIZE-1:0] DataIn,
  output logic                 DataWaitreq,
  output logic                 AddrError
);
  localparam int         ADDR_BITS = $clog2(DEPTH);
  localparam logic [2:0] LAT       = 3'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t               state, next_state;
  logic [2:0]           count, next_count;
  logic [WORD_SIZE-1:0] read_reg;
  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [WORD_SIZE-1:0] lookup;
  logic [ADDR_BITS-1:0] index;
  logic                 request;
  logic                 is_read;
  logic                 capture;
  logic                 complete;
  logic                 commit;
  logic                 out_of_range;

  assign request = ReadData | WriteData;
  assign is_read = ReadData & ~WriteData;
  assign index   = DataAddr[ADDR_BITS-1:0];

`ifdef DATA_MEM_BOUNDS_CHECK_EN
  assign out_of_range = ({1'b0, DataAddr} >= (WORD_SIZE+1)'(DEPTH));
  assign lookup       = out_of_range ? WORD_SIZE'(16'hDEAD) : mem[index];

  always_ff @(posedge Clock) begin
    if (Reset)
      AddrError <= 1'b0;
    else if (complete && out_of_range)
      AddrError <= 1'b1;
  end
`else
  logic unused_addr_bits;

  assign out_of_range     = 1'b0;
  assign lookup           = mem[index];
  assign unused_addr_bits = ^DataAddr;
  assign AddrError        = 1'b0;
`endif

  // An access only commits once it completes, and never in a reset cycle.
  assign commit = complete & WriteData & ~out_of_range & ~Reset;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      count    <= '0;
      read_reg <= '0;
    end else begin
      state <= next_state;
      count <= next_count;
      if (capture)
        read_reg <= is_read ? lookup : '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (commit)
      mem[index] <= DataOut;
  end

  always_comb begin
    next_state  = state;
    next_count  = count;
    DataWaitreq = 1'b0;
    capture     = 1'b0;
    complete    = 1'b0;
    DataIn      = '0;
    case (state)
      IDLE: begin
        if (request) begin
          if (LATENCY == 0) begin
            complete = 1'b1;
            if (is_read)
              DataIn = lookup;
          end else begin
            DataWaitreq = 1'b1;
            if (LATENCY == 1) begin
              next_state = RESP;
              capture    = 1'b1;
            end else begin
              next_state = WAIT;
              next_count = LAT - 3'd1;
            end
          end
        end
      end
      WAIT: begin
        DataWaitreq = 1'b1;
        if (!request) begin
          next_state = IDLE;
          next_count = '0;
        end else begin
          next_count = count - 3'd1;
          if (count == 3'd1) begin
            next_state = RESP;
            capture    = 1'b1;
          end
        end
      end
      RESP: begin
        complete   = 1'b1;
        next_state = IDLE;
        DataIn     = read_reg;
      end
      default: begin
        next_state = IDLE;
        next_count = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_data_memory_responder.sv
// Randomised bench for data_memory_responder: three instances (LATENCY 2, 0, 3) against an array model.
// Honours DATA_MEM_BOUNDS_CHECK_EN for the out-of-range expectations.
module tb_data_memory_responder;
  localparam int NUM_UNITS = 3;
`ifdef DATA_MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clock;
  logic        reset      [NUM_UNITS];
  logic [15:0] addr       [NUM_UNITS];
  logic [15:0] wdata      [NUM_UNITS];
  logic        rd         [NUM_UNITS];
  logic        wr         [NUM_UNITS];
  logic [15:0] data_in    [NUM_UNITS];
  logic        waitreq    [NUM_UNITS];
  logic        addr_error [NUM_UNITS];

  logic [15:0] model_mem [NUM_UNITS][256];
  bit          model_err [NUM_UNITS];
  int          checks   = 0;
  int          failures = 0;

  data_memory_responder #(.WORD_SIZE(16), .DEPTH(256), .LATENCY(2)) u_lat2 (
    .Clock(clock), .Reset(reset[0]), .DataAddr(addr[0]), .DataOut(wdata[0]),
    .ReadData(rd[0]), .WriteData(wr[0]), .DataIn(data_in[0]),
    .DataWaitreq(waitreq[0]), .AddrError(addr_error[0]));

  data_memory_responder #(.WORD_SIZE(16), .DEPTH(256), .LATENCY(0)) u_lat0 (
    .Clock(clock), .Reset(reset[1]), .DataAddr(addr[1]), .DataOut(wdata[1]),
    .ReadData(rd[1]), .WriteData(wr[1]), .DataIn(data_in[1]),
    .DataWaitreq(waitreq[1]), .AddrError(addr_error[1]));

  data_memory_responder #(.WORD_SIZE(16), .DEPTH(256), .LATENCY(3)) u_lat3 (
    .Clock(clock), .Reset(reset[2]), .DataAddr(addr[2]), .DataOut(wdata[2]),
    .ReadData(rd[2]), .WriteData(wr[2]), .DataIn(data_in[2]),
    .DataWaitreq(waitreq[2]), .AddrError(addr_error[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int lat_of(int u);
    case (u)
      0:       return 2;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic bit oob(logic [15:0] a);
    return BOUNDS && (a >= 16'd256);
  endfunction

  function automatic logic [15:0] model_read(int u, logic [15:0] a);
    if (oob(a))
      return 16'hDEAD;
    return model_mem[u][a[7:0]];
  endfunction

  task automatic checkOutput(string tag, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that completes the access.
  task automatic applyStimulus(int u, bit r, bit w, logic [15:0] a, logic [15:0] d);
    int          waits;
    bit          wait_data_bad;
    logic [15:0] exp_data;
    exp_data = (r && !w) ? model_read(u, a) : 16'h0000;
    rd[u] = r; wr[u] = w; addr[u] = a; wdata[u] = d;
    waits = 0;
    wait_data_bad = 1'b0;
    @(negedge clock);
    while (waitreq[u] === 1'b1 && waits < 16) begin
      waits++;
      if (data_in[u] !== 16'h0000)
        wait_data_bad = 1'b1;
      @(negedge clock);
    end
    checkOutput($sformatf("u%0d_waitreq_cycles", u), waits, lat_of(u));
    checkOutput($sformatf("u%0d_datain_while_waiting", u), wait_data_bad, 0);
    checkOutput($sformatf("u%0d_data_in@%0h", u, a), data_in[u], exp_data);
    @(posedge clock);
    #1;
    if (w && !oob(a))
      model_mem[u][a[7:0]] = d;
    if (oob(a))
      model_err[u] = 1'b1;
    checkOutput($sformatf("u%0d_addr_error", u), addr_error[u], model_err[u]);
  endtask

  task automatic applyIdle(int u, int n);
    rd[u] = 1'b0;
    wr[u] = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Request is withdrawn after k edges, i.e. while the unit is still in its wait phase.
  task automatic applyAbort(int u, bit r, logic [15:0] a, logic [15:0] d, int k);
    rd[u] = r; wr[u] = !r; addr[u] = a; wdata[u] = d;
    repeat (k) @(posedge clock);
    #1;
    rd[u] = 1'b0;
    wr[u] = 1'b0;
    @(negedge clock);
    checkOutput($sformatf("u%0d_abort_datain_wait", u), data_in[u], 0);
    @(negedge clock);
    checkOutput($sformatf("u%0d_abort_waitreq", u), waitreq[u], 0);
    checkOutput($sformatf("u%0d_abort_datain_idle", u), data_in[u], 0);
    @(posedge clock);
    #1;
  endtask

  // Inputs are left as they are during the reset cycle so an in-flight access sees Reset.
  task automatic applyReset(int u);
    reset[u] = 1'b1;
    @(posedge clock);
    #1;
    reset[u] = 1'b0;
    rd[u] = 1'b0;
    wr[u] = 1'b0;
    model_err[u] = 1'b0;
    @(negedge clock);
    checkOutput($sformatf("u%0d_reset_waitreq", u), waitreq[u], 0);
    checkOutput($sformatf("u%0d_reset_datain", u), data_in[u], 0);
    checkOutput($sformatf("u%0d_reset_addr_error", u), addr_error[u], 0);
    @(posedge clock);
    #1;
  endtask

  task automatic runRandom(int u, int n);
    int          op;
    int          lat;
    logic [15:0] a;
    logic [15:0] d;
    lat = lat_of(u);
    for (int i = 0; i < n; i++) begin
      op = int'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0)
        a = 16'($urandom);
      else
        a = {8'h00, 8'($urandom)};
      d = 16'($urandom);
      if (op == 9 && lat >= 2)
        applyAbort(u, 1'($urandom_range(0, 1)), {8'h00, a[7:0]}, d, int'($urandom_range(1, lat - 1)));
      else if (op < 5)
        applyStimulus(u, 1'b1, 1'b0, a, d);
      else if (op < 8)
        applyStimulus(u, 1'b0, 1'b1, a, d);
      else
        applyStimulus(u, 1'b1, 1'b1, a, d);
      if ($urandom_range(0, 3) == 0)
        applyIdle(u, int'($urandom_range(1, 2)));
    end
    applyIdle(u, 1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL timeout: bench did not reach its summary");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [15:0] prior;
    for (int u = 0; u < NUM_UNITS; u++) begin
      reset[u] = 1'b1; rd[u] = 1'b0; wr[u] = 1'b0;
      addr[u] = '0; wdata[u] = '0; model_err[u] = 1'b0;
    end
    repeat (2) @(posedge clock);
    #1;
    for (int u = 0; u < NUM_UNITS; u++) reset[u] = 1'b0;
    @(negedge clock);
    for (int u = 0; u < NUM_UNITS; u++) begin
      checkOutput($sformatf("u%0d_por_waitreq", u), waitreq[u], 0);
      checkOutput($sformatf("u%0d_por_datain", u), data_in[u], 0);
      checkOutput($sformatf("u%0d_por_addr_error", u), addr_error[u], 0);
    end
    @(posedge clock);
    #1;

    // Give every location a known value so any later read has a defined expectation.
    for (int u = 0; u < NUM_UNITS; u++) begin
      for (int a = 0; a < 256; a++)
        applyStimulus(u, 1'b0, 1'b1, 16'(a), 16'($urandom));
      applyIdle(u, 1);
    end

    applyStimulus(0, 1'b0, 1'b1, 16'd5, 16'h1234);
    applyStimulus(0, 1'b1, 1'b0, 16'd5, 16'h0000);
    applyIdle(0, 1);

    applyStimulus(1, 1'b0, 1'b1, 16'd9, 16'hBEEF);
    applyStimulus(1, 1'b1, 1'b0, 16'd9, 16'h0000);
    applyIdle(1, 1);

    applyStimulus(2, 1'b0, 1'b1, 16'd1, 16'h0011);
    applyStimulus(2, 1'b0, 1'b1, 16'd2, 16'h0022);
    applyIdle(2, 1);
    applyStimulus(2, 1'b1, 1'b0, 16'd1, 16'h0000);
    applyStimulus(2, 1'b1, 1'b0, 16'd2, 16'h0000);
    applyIdle(2, 1);

    prior = model_mem[0][7];
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 16'd7; wdata[0] = 16'hAAAA;
    @(posedge clock);
    #1;
    applyReset(0);
    applyStimulus(0, 1'b1, 1'b0, 16'd7, 16'h0000);
    checkOutput("u0_write_killed_by_reset_in_wait", model_mem[0][7], prior);

    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 16'd8; wdata[0] = 16'h5555;
    repeat (2) @(posedge clock);
    #1;
    applyReset(0);
    applyStimulus(0, 1'b1, 1'b0, 16'd8, 16'h0000);
    applyIdle(0, 1);

    applyAbort(0, 1'b1, 16'd5, 16'h0000, 1);
    applyAbort(2, 1'b0, 16'd3, 16'h7777, 2);
    applyStimulus(2, 1'b1, 1'b0, 16'd3, 16'h0000);
    applyIdle(2, 1);

    applyStimulus(0, 1'b1, 1'b0, 16'h0100, 16'h0000);
    applyStimulus(0, 1'b1, 1'b0, 16'd5, 16'h0000);
    applyIdle(0, 2);
    checkOutput("u0_addr_error_sticky", addr_error[0], BOUNDS);
    applyReset(0);

    for (int u = 0; u < NUM_UNITS; u++)
      runRandom(u, 80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
